// File: rtl/raiz_pkg.sv
// Shared types and defaults for the raiz_sched square-root request scheduler.
package raiz_pkg;

    localparam int RAIZ_W_DEF       = 16;
    localparam int RAIZ_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to the
// requester that was not served last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // NOTE: every combinational output gets a default first so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/raiz_sched.sv
// Shares one square-root core between two requesters (IDLE/LAUNCH/WAIT/RESP).
// Optional WAIT timeout with error response when RAIZ_TIMEOUT_EN is defined.
module raiz_sched
    import raiz_pkg::*;
#(
    parameter int W       = RAIZ_W_DEF,
    parameter int TIMEOUT = RAIZ_TIMEOUT_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [1:0]   REQ_V,
    input  logic [W-1:0] REQ_A0,
    input  logic [W-1:0] REQ_A1,
    output logic [1:0]   REQ_RDY,
    output logic [1:0]   RSP_V,
    output logic [W-1:0] RSP_D,
    output logic         RSP_ERR,
    output logic         BUSY,
    output logic         CORE_INIT,
    output logic [W-1:0] CORE_OP_A,
    input  logic         CORE_DONE,
    input  logic [W-1:0] CORE_RES
);

    state_e       state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_q, last_d;
    logic [W-1:0] op_a_q, op_a_d;
    logic [W-1:0] rsp_d_q, rsp_d_d;
    logic         first_wait_q, first_wait_d;
    logic         rsp_err_d;
    logic [1:0]   gnt;

    rr_arb2 u_arb (
        .req_i  (REQ_V),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

`ifdef RAIZ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0) ^ rsp_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        op_a_d       = op_a_q;
        rsp_d_d      = rsp_d_q;
        first_wait_d = first_wait_q;
        rsp_err_d    = 1'b0;
`ifdef RAIZ_TIMEOUT_EN
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    op_a_d  = gnt[1] ? REQ_A1 : REQ_A0;
                    owner_d = gnt[1];
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                first_wait_d = 1'b1;
                state_d      = ST_WAIT;
`ifdef RAIZ_TIMEOUT_EN
                cnt_d        = '0;
`endif
            end
            ST_WAIT: begin
                // The first WAIT cycle may still see DONE left over from the previous run.
                first_wait_d = 1'b0;
`ifdef RAIZ_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (!first_wait_q && CORE_DONE) begin
                    rsp_d_d   = CORE_RES;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end
`ifdef RAIZ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_d_d   = '1;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            op_a_q       <= '0;
            rsp_d_q      <= '0;
            first_wait_q <= 1'b0;
`ifdef RAIZ_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            op_a_q       <= op_a_d;
            rsp_d_q      <= rsp_d_d;
            first_wait_q <= first_wait_d;
`ifdef RAIZ_TIMEOUT_EN
            cnt_q        <= cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign REQ_RDY   = (state_q == ST_IDLE) ? gnt : 2'b00;
    assign RSP_V     = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign RSP_D     = rsp_d_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign CORE_INIT = (state_q == ST_LAUNCH);
    assign CORE_OP_A = op_a_q;
`ifdef RAIZ_TIMEOUT_EN
    assign RSP_ERR   = rsp_err_q;
`else
    assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_raiz_sched.sv
// Directed bench for raiz_sched with a behavioural square-root core that holds
// DONE into the next run so the stale-DONE mask is exercised.
module tb_raiz_sched;

    localparam int W   = 16;
    localparam int TO  = 32;
    localparam int LAT = 17;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_v = 2'b00;
    logic [W-1:0] a0 = '0;
    logic [W-1:0] a1 = '0;
    logic [1:0]   rdy, rsp_v;
    logic [W-1:0] rsp_d, core_op_a;
    logic         rsp_err, busy, core_init;
    logic         core_done = 1'b0;
    logic [W-1:0] core_res = '0;

    int n_vec = 0;
    int n_bad = 0;
    bit stuck = 1'b0;

    raiz_sched #(.W(W), .TIMEOUT(TO)) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_V     (req_v),
        .REQ_A0    (a0),
        .REQ_A1    (a1),
        .REQ_RDY   (rdy),
        .RSP_V     (rsp_v),
        .RSP_D     (rsp_d),
        .RSP_ERR   (rsp_err),
        .BUSY      (busy),
        .CORE_INIT (core_init),
        .CORE_OP_A (core_op_a),
        .CORE_DONE (core_done),
        .CORE_RES  (core_res)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return W'(r);
    endfunction

    // Core model: DONE visible LAT cycles after the INIT cycle, stays high
    // until one cycle after the next INIT.
    logic [W-1:0] m_op  = '0;
    int           m_cnt = 0;
    bit           m_run = 1'b0;
    bit           m_clr = 1'b0;

    always @(posedge clk) begin
        if (core_init) begin
            m_op  <= core_op_a;
            m_cnt <= LAT - 1;
            m_run <= 1'b1;
            m_clr <= 1'b1;
        end else begin
            if (m_clr) begin
                core_done <= 1'b0;
                m_clr     <= 1'b0;
            end
            if (m_run) begin
                if (m_cnt == 1) begin
                    m_run <= 1'b0;
                    if (!stuck) begin
                        core_done <= 1'b1;
                        core_res  <= isqrt(m_op);
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(input int max, output int n, output logic [1:0] v, output int inits);
        bit seen = 1'b0;
        n = 0;
        v = 2'b00;
        inits = 0;
        for (int i = 1; i <= max && !seen; i++) begin
            @(negedge clk);
            if (core_init) inits++;
            if (rsp_v != 2'b00) begin
                n = i;
                v = rsp_v;
                seen = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_v = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int         n, inits;
        logic [1:0] v;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_v", 32'(rsp_v), 0);
        check("rst_rsp_d", 32'(rsp_d), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_init", 32'(core_init), 0);
        check("rst_op_a", 32'(core_op_a), 0);
        check("rst_rdy", 32'(rdy), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single request 144 -> 12
        req_v = 2'b11;
        #1 check("tie_rdy_after_rst", 32'(rdy), 32'h1);
        req_v = 2'b01;
        a0    = 16'd144;
        #1 check("single_rdy", 32'(rdy), 32'h1);
        @(negedge clk);
        check("single_init", 32'(core_init), 1);
        check("single_op_a", 32'(core_op_a), 144);
        check("single_busy", 32'(busy), 1);
        check("single_rdy_launch", 32'(rdy), 0);
        req_v = 2'b00;
        wait_rsp(100, n, v, inits);
        check("single_lat", 32'(n), 18);
        check("single_rsp_v", 32'(v), 32'h1);
        check("single_rsp_d", 32'(rsp_d), 12);
        check("single_err", 32'(rsp_err), 0);
        check("single_extra_init", 32'(inits), 0);
        @(negedge clk);
        check("single_pulse_end", 32'(rsp_v), 0);
        check("single_idle", 32'(busy), 0);
        check("single_hold_d", 32'(rsp_d), 12);

        // Tie after reset: 81 -> 9 to req0, then 256 -> 16 to req1
        do_reset();
        req_v = 2'b11;
        a0    = 16'd81;
        a1    = 16'd256;
        #1 check("tie_rdy", 32'(rdy), 32'h1);
        @(negedge clk);
        check("tie_op_a0", 32'(core_op_a), 81);
        req_v = 2'b10;
        wait_rsp(100, n, v, inits);
        check("tie_rsp_v0", 32'(v), 32'h1);
        check("tie_rsp_d0", 32'(rsp_d), 9);
        @(negedge clk);
        check("tie_rdy1", 32'(rdy), 32'h2);
        @(negedge clk);
        check("tie_init1", 32'(core_init), 1);
        check("tie_op_a1", 32'(core_op_a), 256);
        req_v = 2'b00;
        wait_rsp(100, n, v, inits);
        check("tie_rsp_v1", 32'(v), 32'h2);
        check("tie_rsp_d1", 32'(rsp_d), 16);
        check("stale_done_lat", 32'(n), 18);

        // Fairness plus request during WAIT
        @(negedge clk);
        req_v = 2'b01;
        a0    = 16'd100;
        a1    = 16'd625;
        #1 check("fair_rdy0", 32'(rdy), 32'h1);
        @(negedge clk);
        @(negedge clk);
        req_v = 2'b11;
        #1 check("wait_rdy", 32'(rdy), 0);
        wait_rsp(100, n, v, inits);
        check("wait_no_init", 32'(inits), 0);
        check("fair_rsp_v0", 32'(v), 32'h1);
        check("fair_rsp_d0", 32'(rsp_d), 10);
        @(negedge clk);
        check("fair_rdy1", 32'(rdy), 32'h2);
        @(negedge clk);
        check("fair_op_a1", 32'(core_op_a), 625);
        req_v = 2'b00;
        wait_rsp(100, n, v, inits);
        check("fair_rsp_v1", 32'(v), 32'h2);
        check("fair_rsp_d1", 32'(rsp_d), 25);

        // Reset during WAIT drops the transaction
        @(negedge clk);
        req_v = 2'b01;
        a0    = 16'd200;
        @(negedge clk);
        req_v = 2'b00;
        repeat (5) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        wait_rsp(40, n, v, inits);
        check("midrst_no_rsp", 32'(v), 0);
        check("midrst_idle", 32'(busy), 0);
        req_v = 2'b01;
        a0    = 16'd49;
        @(negedge clk);
        req_v = 2'b00;
        wait_rsp(100, n, v, inits);
        check("midrst_rsp_v", 32'(v), 32'h1);
        check("midrst_rsp_d", 32'(rsp_d), 7);

        // Core DONE stuck low
        @(negedge clk);
        stuck = 1'b1;
        req_v = 2'b01;
        a0    = 16'd5;
        @(negedge clk);
        req_v = 2'b00;
        wait_rsp(1000, n, v, inits);
`ifdef RAIZ_TIMEOUT_EN
        check("to_rsp_v", 32'(v), 32'h1);
        check("to_err", 32'(rsp_err), 1);
        check("to_rsp_d", 32'(rsp_d), 32'hFFFF);
        check("to_lat", 32'(n), 33);
`else
        check("no_to_rsp_v", 32'(v), 0);
        check("no_to_busy", 32'(busy), 1);
`endif

        // Max operand after recovery
        do_reset();
        stuck = 1'b0;
        req_v = 2'b01;
        a0    = 16'hFFFF;
        @(negedge clk);
        req_v = 2'b00;
        wait_rsp(100, n, v, inits);
        check("max_rsp_v", 32'(v), 32'h1);
        check("max_rsp_d", 32'(rsp_d), 255);
        check("max_err", 32'(rsp_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
